// File: rtl/voice_phase_bank.sv
// voice_phase_bank
//   Time-multiplexed phase-accumulator bank feeding the quarter-sine stage.
//   NBANKS voice slots each hold a phase accumulator, tuning word, MIDI note
//   and active flag. One slot is visited per clk_en cycle in fixed order
//   0..NBANKS-1. Its pre-increment phase, note and active flag are registered
//   onto the outputs, and its accumulator advances if the slot is active.
//   Note-on/off commands go through an IDLE -> SCAN -> COMMIT allocator.
//   SCAN walks every slot to find a matching or free slot. COMMIT applies
//   the command.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   clk_en           global advance enable; nothing changes while low
//   i_cmd_valid      command present
//   o_cmd_ready      allocator idle, command can be accepted
//   i_cmd_on         1 = note-on, 0 = note-off
//   i_cmd_midi       MIDI note of the command
//   i_cmd_tw         tuning word for note-on
//   o_cmd_done       command applied (held while clk_en is low)
//   o_overflow       note-on dropped, no free slot (held while clk_en is low)
//   o_phase          top 16 bits of the emitted slot's accumulator
//   o_midi           MIDI note of the emitted slot
//   o_valid          active flag of the emitted slot
//   o_slot           index of the emitted slot
//   o_active_cnt     number of active slots
module voice_phase_bank #(
    parameter int NBANKS  = 10,
    parameter int PHASE_W = 32,
    parameter int SLOT_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_cmd_on,
    input  logic [6:0]         i_cmd_midi,
    input  logic [PHASE_W-1:0] i_cmd_tw,
    output logic               o_cmd_done,
    output logic               o_overflow,
    output logic [15:0]        o_phase,
    output logic [6:0]         o_midi,
    output logic               o_valid,
    output logic [SLOT_W-1:0]  o_slot,
    output logic [SLOT_W:0]    o_active_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NBANKS - 1);

    state_t state_q, state_d;

    // Per-slot voice state
    logic [PHASE_W-1:0] acc_q  [NBANKS];
    logic [PHASE_W-1:0] acc_d  [NBANKS];
    logic [PHASE_W-1:0] tw_q   [NBANKS];
    logic [PHASE_W-1:0] tw_d   [NBANKS];
    logic [6:0]         midi_q [NBANKS];
    logic [6:0]         midi_d [NBANKS];
    logic [NBANKS-1:0]  active_q, active_d;

    // Rotation pointer
    logic [SLOT_W-1:0]  sp_q, sp_d;

    // Latched command and scan results
    logic               cmd_on_q, cmd_on_d;
    logic [6:0]         cmd_midi_q, cmd_midi_d;
    logic [PHASE_W-1:0] cmd_tw_q, cmd_tw_d;
    logic [SLOT_W-1:0]  scan_idx_q, scan_idx_d;
    logic               match_found_q, match_found_d;
    logic [SLOT_W-1:0]  match_idx_q, match_idx_d;
    logic               free_found_q, free_found_d;
    logic [SLOT_W-1:0]  free_idx_q, free_idx_d;

    // Registered emission and count
    logic [15:0]        phase_q, phase_d;
    logic [6:0]         midi_out_q, midi_out_d;
    logic               valid_q, valid_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [SLOT_W:0]    cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // State register and all other flops; everything advances on clk_en
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            for (int unsigned i = 0; i < NBANKS; i++) begin
                acc_q[i]  <= '0;
                tw_q[i]   <= '0;
                midi_q[i] <= '0;
            end
            active_q      <= '0;
            sp_q          <= '0;
            cmd_on_q      <= 1'b0;
            cmd_midi_q    <= '0;
            cmd_tw_q      <= '0;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            phase_q       <= '0;
            midi_out_q    <= '0;
            valid_q       <= 1'b0;
            slot_q        <= '0;
            cnt_q         <= '0;
        end else if (clk_en) begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            tw_q          <= tw_d;
            midi_q        <= midi_d;
            active_q      <= active_d;
            sp_q          <= sp_d;
            cmd_on_q      <= cmd_on_d;
            cmd_midi_q    <= cmd_midi_d;
            cmd_tw_q      <= cmd_tw_d;
            scan_idx_q    <= scan_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            phase_q       <= phase_d;
            midi_out_q    <= midi_out_d;
            valid_q       <= valid_d;
            slot_q        <= slot_d;
            cnt_q         <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_cmd_valid) state_d = ST_SCAN;
            ST_SCAN:   if (scan_idx_q == LAST_SLOT) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs: pulses are decoded from the registered COMMIT state,
    // so they naturally hold while clk_en is low.
    // ------------------------------------------------------------------
    always_comb begin
        o_cmd_ready = (state_q == ST_IDLE);
        o_cmd_done  = (state_q == ST_COMMIT);
        o_overflow  = (state_q == ST_COMMIT) && cmd_on_q
                      && !match_found_q && !free_found_q;
    end

    // ------------------------------------------------------------------
    // Datapath: emission, accumulation, scan bookkeeping, commit
    // ------------------------------------------------------------------
    always_comb begin
        acc_d         = acc_q;
        tw_d          = tw_q;
        midi_d        = midi_q;
        active_d      = active_q;
        cmd_on_d      = cmd_on_q;
        cmd_midi_d    = cmd_midi_q;
        cmd_tw_d      = cmd_tw_q;
        scan_idx_d    = scan_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        cnt_d         = cnt_q;

        // Emit the visited slot using its pre-increment accumulator
        phase_d    = acc_q[sp_q][PHASE_W-1 -: 16];
        midi_out_d = midi_q[sp_q];
        valid_d    = active_q[sp_q];
        slot_d     = sp_q;
        sp_d       = (sp_q == LAST_SLOT) ? '0 : sp_q + SLOT_W'(1);

        if (active_q[sp_q]) begin
            acc_d[sp_q] = acc_q[sp_q] + tw_q[sp_q];
        end

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    cmd_on_d      = i_cmd_on;
                    cmd_midi_d    = i_cmd_midi;
                    cmd_tw_d      = i_cmd_tw;
                    scan_idx_d    = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                end
            end
            ST_SCAN: begin
                if (!match_found_q && active_q[scan_idx_q]
                    && midi_q[scan_idx_q] == cmd_midi_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_idx_q;
                end
                if (!free_found_q && !active_q[scan_idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                if (scan_idx_q != LAST_SLOT) begin
                    scan_idx_d = scan_idx_q + SLOT_W'(1);
                end
            end
            ST_COMMIT: begin
                // Written after the accumulate step so a commit to the
                // currently visited slot takes precedence over its advance.
                if (cmd_on_q) begin
                    if (match_found_q) begin
                        acc_d[match_idx_q] = '0;
                        tw_d[match_idx_q]  = cmd_tw_q;
                    end else if (free_found_q) begin
                        acc_d[free_idx_q]    = '0;
                        tw_d[free_idx_q]     = cmd_tw_q;
                        midi_d[free_idx_q]   = cmd_midi_q;
                        active_d[free_idx_q] = 1'b1;
                        cnt_d                = cnt_q + (SLOT_W + 1)'(1);
                    end
                end else if (match_found_q) begin
                    active_d[match_idx_q] = 1'b0;
                    acc_d[match_idx_q]    = '0;
                    cnt_d                 = cnt_q - (SLOT_W + 1)'(1);
                end
            end
            default: ;
        endcase
    end

    assign o_phase      = phase_q;
    assign o_midi       = midi_out_q;
    assign o_valid      = valid_q;
    assign o_slot       = slot_q;
    assign o_active_cnt = cnt_q;

endmodule

// File: tb/tb_voice_phase_bank.sv
// tb_voice_phase_bank
//   Self-checking bench for voice_phase_bank. A behavioural model holds the
//   voice table as plain arrays. Each clk_en edge it emits the visited slot,
//   advances it, and applies a pending command NBANKS+1 enable cycles after
//   acceptance, choosing the slot by direct search of the table.
module tb_voice_phase_bank;

    localparam int NB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        i_cmd_on = 1'b0;
    logic [6:0]  i_cmd_midi = '0;
    logic [31:0] i_cmd_tw = '0;
    logic        o_cmd_ready, o_cmd_done, o_overflow, o_valid;
    logic [15:0] o_phase;
    logic [6:0]  o_midi;
    logic [3:0]  o_slot;
    logic [4:0]  o_active_cnt;

    voice_phase_bank #(.NBANKS(NB), .PHASE_W(32), .SLOT_W(4)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_on(i_cmd_on), .i_cmd_midi(i_cmd_midi), .i_cmd_tw(i_cmd_tw),
        .o_cmd_done(o_cmd_done), .o_overflow(o_overflow),
        .o_phase(o_phase), .o_midi(o_midi), .o_valid(o_valid),
        .o_slot(o_slot), .o_active_cnt(o_active_cnt)
    );

    always #5 clk = ~clk;

    logic [35:0] dut_vec;
    assign dut_vec = {o_cmd_ready, o_cmd_done, o_overflow, o_phase, o_midi,
                      o_valid, o_slot, o_active_cnt};

    int total_cnt = 0;
    int pass_cnt  = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        on;
        logic [6:0]  midi;
        logic [31:0] tw;
    } cmd_t;

    cmd_t        cmd_q[$];
    bit          drove_q, noise;
    logic [31:0] m_acc [NB];
    logic [31:0] m_tw  [NB];
    logic [6:0]  m_midi[NB];
    bit          m_active[NB];
    int          m_sp, m_wait, m_cnt, ecyc, acc_cyc;
    bit          m_busy, m_on;
    logic [6:0]  m_cmidi;
    logic [31:0] m_ctw;
    logic [15:0] e_phase;
    logic [6:0]  e_midi;
    logic        e_valid;
    logic [3:0]  e_slot;
    logic [35:0] exp_vec;

    function automatic cmd_t mk(input logic on, input logic [6:0] midi, input logic [31:0] tw);
        cmd_t c;
        c.on = on; c.midi = midi; c.tw = tw;
        return c;
    endfunction

    function automatic int find_match(input logic [6:0] m);
        for (int i = 0; i < NB; i++) if (m_active[i] && m_midi[i] == m) return i;
        return -1;
    endfunction

    function automatic int find_free();
        for (int i = 0; i < NB; i++) if (!m_active[i]) return i;
        return -1;
    endfunction

    function automatic void build_exp();
        logic d, o;
        d = m_busy && (m_wait == NB);
        o = d && m_on && (find_match(m_cmidi) < 0) && (find_free() < 0);
        exp_vec = {~m_busy, d, o, e_phase, e_midi, e_valid, e_slot, 5'(m_cnt)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_acc[i] = '0; m_tw[i] = '0; m_midi[i] = '0; m_active[i] = 1'b0;
        end
        m_sp = 0; m_wait = 0; m_cnt = 0; m_busy = 1'b0; m_on = 1'b0;
        m_cmidi = '0; m_ctw = '0; ecyc = 0; acc_cyc = -1;
        e_phase = '0; e_midi = '0; e_valid = 1'b0; e_slot = '0;
        cmd_q.delete();
        build_exp();
    endfunction

    function automatic void model_edge();
        int s, mi, fi;
        s = m_sp;
        e_phase = m_acc[s][31:16];
        e_midi  = m_midi[s];
        e_valid = m_active[s];
        e_slot  = 4'(s);
        if (m_active[s]) m_acc[s] = m_acc[s] + m_tw[s];
        if (m_busy && m_wait == NB) begin
            mi = find_match(m_cmidi);
            fi = find_free();
            if (m_on) begin
                if (mi >= 0) begin
                    m_acc[mi] = '0; m_tw[mi] = m_ctw;
                end else if (fi >= 0) begin
                    m_acc[fi] = '0; m_tw[fi] = m_ctw; m_midi[fi] = m_cmidi;
                    m_active[fi] = 1'b1; m_cnt++;
                end
            end else if (mi >= 0) begin
                m_active[mi] = 1'b0; m_acc[mi] = '0; m_cnt--;
            end
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_wait++;
        end else if (i_cmd_valid) begin
            m_busy = 1'b1; m_wait = 0;
            m_on = i_cmd_on; m_cmidi = i_cmd_midi; m_ctw = i_cmd_tw;
            acc_cyc = ecyc;
            if (drove_q) void'(cmd_q.pop_front());
        end
        m_sp = (s + 1) % NB;
        ecyc++;
        build_exp();
    endfunction

    // Drive one clock: inputs set here, model advanced at the edge, return
    // 1 time unit after the edge so outputs can be sampled.
    task automatic step(input bit en);
        clk_en = en;
        if (cmd_q.size() > 0) begin
            drove_q     = 1'b1;
            i_cmd_valid = 1'b1;
            i_cmd_on    = cmd_q[0].on;
            i_cmd_midi  = cmd_q[0].midi;
            i_cmd_tw    = cmd_q[0].tw;
        end else begin
            drove_q = 1'b0;
            if (noise) begin
                i_cmd_valid = 1'($urandom_range(0, 1));
                i_cmd_on    = ($urandom_range(0, 4) != 0);
                i_cmd_midi  = 7'($urandom_range(0, 15));
                i_cmd_tw    = $urandom;
            end else begin
                i_cmd_valid = 1'b0;
            end
        end
        @(posedge clk);
        if (en && !rst) model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        noise = 1'b0;
        model_reset();
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (dut_vec !== exp_vec) $display("FAIL reset_state: got %h want %h", dut_vec, exp_vec);
        else pass_cnt++;
        cmd_q.push_back(mk(1'b1, 7'd60, 32'h0001_0000));
        for (int n = 0; n < 5; n++) begin
            step(1'b1);
            total_cnt++;
            if (dut_vec !== exp_vec) $display("FAIL reset_prestream: got %h want %h (cyc %0d)", dut_vec, exp_vec, ecyc);
            else pass_cnt++;
        end
        rst = 1'b1;
        #1;
        model_reset();
        total_cnt++;
        if (dut_vec !== exp_vec) $display("FAIL reset_async: got %h want %h", dut_vec, exp_vec);
        else pass_cnt++;
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
        for (int n = 0; n < NB; n++) begin
            step(1'b1);
            total_cnt++;
            if (o_valid !== 1'b0) $display("FAIL reset_valid_low: got %b want 0 (cyc %0d)", o_valid, ecyc);
            else pass_cnt++;
            total_cnt++;
            if (dut_vec !== exp_vec) $display("FAIL reset_rotation: got %h want %h (cyc %0d)", dut_vec, exp_vec, ecyc);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_note();
        int done_cyc = -1, ready_cyc = -1, k = 0;
        do_reset();
        cmd_q.push_back(mk(1'b1, 7'd60, 32'h0001_0000));
        for (int n = 0; n < 80; n++) begin
            step(1'b1);
            total_cnt++;
            if (dut_vec !== exp_vec) $display("FAIL single_vec: got %h want %h (cyc %0d)", dut_vec, exp_vec, ecyc);
            else pass_cnt++;
            if (o_cmd_done === 1'b1 && done_cyc < 0) done_cyc = ecyc;
            if (done_cyc >= 0 && o_cmd_ready === 1'b1 && ready_cyc < 0) ready_cyc = ecyc;
            if (o_valid === 1'b1) begin
                total_cnt++;
                if (o_slot !== 4'd0 || o_midi !== 7'd60 || o_phase !== 16'(k))
                    $display("FAIL single_phase: got slot %0d midi %0d phase %h want slot 0 midi 60 phase %h",
                             o_slot, o_midi, o_phase, 16'(k));
                else pass_cnt++;
                k++;
            end
        end
        total_cnt++;
        if (done_cyc - acc_cyc !== NB + 1) $display("FAIL single_done_latency: got %0d want %0d", done_cyc - acc_cyc, NB + 1);
        else pass_cnt++;
        total_cnt++;
        if (ready_cyc - acc_cyc !== NB + 2) $display("FAIL single_ready_latency: got %0d want %0d", ready_cyc - acc_cyc, NB + 2);
        else pass_cnt++;
        total_cnt++;
        if (k !== 6) $display("FAIL single_emission_count: got %0d want 6", k);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int k = 0, ovf = 0;
        do_reset();
        cmd_q.push_back(mk(1'b1, 7'd72, 32'h8000_0000));
        for (int n = 0; n < 80; n++) begin
            step(1'b1);
            total_cnt++;
            if (dut_vec !== exp_vec) $display("FAIL wrap_vec: got %h want %h (cyc %0d)", dut_vec, exp_vec, ecyc);
            else pass_cnt++;
            if (o_overflow === 1'b1) ovf++;
            if (o_valid === 1'b1) begin
                total_cnt++;
                if (o_phase !== ((k % 2) ? 16'h8000 : 16'h0000))
                    $display("FAIL wrap_phase: got %h want %h", o_phase, (k % 2) ? 16'h8000 : 16'h0000);
                else pass_cnt++;
                k++;
            end
        end
        total_cnt++;
        if (ovf !== 0) $display("FAIL wrap_no_overflow: got %0d pulses want 0", ovf);
        else pass_cnt++;
        total_cnt++;
        if (k !== 6) $display("FAIL wrap_emission_count: got %0d want 6", k);
        else pass_cnt++;
    endtask

    task automatic test_full();
        int ovf = 0, n = 0;
        do_reset();
        for (int i = 0; i < NB; i++) cmd_q.push_back(mk(1'b1, 7'(20 + i), $urandom | 32'h1));
        cmd_q.push_back(mk(1'b1, 7'd99, 32'h0123_4567));
        while ((cmd_q.size() > 0 || m_busy) && n < 200) begin
            step(1'b1);
            n++;
            total_cnt++;
            if (dut_vec !== exp_vec) $display("FAIL full_vec: got %h want %h (cyc %0d)", dut_vec, exp_vec, ecyc);
            else pass_cnt++;
            if (o_overflow === 1'b1) ovf++;
        end
        total_cnt++;
        if (n >= 200) $display("FAIL full_timeout: got %0d cycles want completion", n);
        else pass_cnt++;
        total_cnt++;
        if (ovf !== 1) $display("FAIL full_overflow: got %0d pulses want 1", ovf);
        else pass_cnt++;
        total_cnt++;
        if (o_active_cnt !== 5'd10) $display("FAIL full_active_cnt: got %0d want 10", o_active_cnt);
        else pass_cnt++;
        for (int r = 0; r < NB; r++) begin
            step(1'b1);
            total_cnt++;
            if (o_valid !== 1'b1 || o_midi !== 7'(20 + int'(e_slot)))
                $display("FAIL full_slot_midi: got valid %b midi %0d want valid 1 midi %0d", o_valid, o_midi, 20 + int'(e_slot));
            else pass_cnt++;
            total_cnt++;
            if (dut_vec !== exp_vec) $display("FAIL full_rotation: got %h want %h (cyc %0d)", dut_vec, exp_vec, ecyc);
            else pass_cnt++;
        end
    endtask

    task automatic test_retrigger_off();
        cmd_t cmds[4];
        int   exp_cnt[4];
        int   dones, k, nval, n;
        cmds[0] = mk(1'b1, 7'd60, 32'h0003_0000); exp_cnt[0] = 1;
        cmds[1] = mk(1'b1, 7'd60, 32'h0005_0000); exp_cnt[1] = 1;
        cmds[2] = mk(1'b0, 7'd61, 32'hFFFF_FFFF); exp_cnt[2] = 1;
        cmds[3] = mk(1'b0, 7'd60, 32'h0000_0000); exp_cnt[3] = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cmd_q.push_back(cmds[c]);
            dones = 0;
            n = 0;
            while ((cmd_q.size() > 0 || m_busy) && n < 40) begin
                step(1'b1);
                n++;
                total_cnt++;
                if (dut_vec !== exp_vec) $display("FAIL retrig_vec: got %h want %h (cmd %0d cyc %0d)", dut_vec, exp_vec, c, ecyc);
                else pass_cnt++;
                if (o_cmd_done === 1'b1) dones++;
            end
            total_cnt++;
            if (dones !== 1) $display("FAIL retrig_done_pulse: got %0d want 1 (cmd %0d)", dones, c);
            else pass_cnt++;
            total_cnt++;
            if (o_active_cnt !== 5'(exp_cnt[c])) $display("FAIL retrig_active_cnt: got %0d want %0d (cmd %0d)", o_active_cnt, exp_cnt[c], c);
            else pass_cnt++;
            k = 0;
            nval = 0;
            for (int m = 0; m < 25; m++) begin
                step(1'b1);
                total_cnt++;
                if (dut_vec !== exp_vec) $display("FAIL retrig_vec_after: got %h want %h (cmd %0d cyc %0d)", dut_vec, exp_vec, c, ecyc);
                else pass_cnt++;
                if (o_valid === 1'b1) begin
                    nval++;
                    if (c == 1) begin
                        total_cnt++;
                        if (o_slot !== 4'd0 || o_phase !== 16'(5 * k))
                            $display("FAIL retrig_restart: got slot %0d phase %h want slot 0 phase %h", o_slot, o_phase, 16'(5 * k));
                        else pass_cnt++;
                        k++;
                    end
                end
            end
            if (c == 3) begin
                total_cnt++;
                if (nval !== 0) $display("FAIL off_no_valid: got %0d valid emissions want 0", nval);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_clk_en_gating();
        int  done_cyc = -1, k = 0;
        bit  en;
        do_reset();
        cmd_q.push_back(mk(1'b1, 7'd64, 32'h0001_0000));
        for (int n = 0; n < 300; n++) begin
            en = ($urandom_range(0, 1) != 0);
            step(en);
            total_cnt++;
            if (dut_vec !== exp_vec) $display("FAIL gate_vec: got %h want %h (en %b cyc %0d)", dut_vec, exp_vec, en, ecyc);
            else pass_cnt++;
            if (o_cmd_done === 1'b1 && done_cyc < 0) done_cyc = ecyc;
            if (en && o_valid === 1'b1) begin
                total_cnt++;
                if (o_phase !== 16'(k)) $display("FAIL gate_phase: got %h want %h", o_phase, 16'(k));
                else pass_cnt++;
                k++;
            end
        end
        total_cnt++;
        if (done_cyc - acc_cyc !== NB + 1) $display("FAIL gate_done_latency: got %0d want %0d", done_cyc - acc_cyc, NB + 1);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        noise = 1'b1;
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0);
            total_cnt++;
            if (dut_vec !== exp_vec) $display("FAIL b2b_vec: got %h want %h (cyc %0d)", dut_vec, exp_vec, ecyc);
            else pass_cnt++;
        end
        noise = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_wrap();
        test_full();
        test_retrigger_off();
        test_clk_en_gating();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
